// File: rtl/register_file32.sv
// 32 x 32-bit register file with hardwired-zero r0, combinational reads,
// registered ALU status flags (sticky overflow) and a wrapping write counter.
module register_file32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWrite,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  input  logic        FlagWrite,
  input  logic        Zero0,
  input  logic        OverFlow,
  input  logic        ClearOvf,
  output logic        FlagZero,
  output logic        FlagOvf,
  output logic [15:0] WriteCount
);

  logic [31:0] r_regs [32];
  logic        r_flag_zero;
  logic        r_flag_ovf;
  logic [15:0] r_write_count;

  logic        w_commit;
  logic        w_ovf_set;

  assign w_commit  = RegWrite && (WriteReg != 5'd0);
  assign w_ovf_set = FlagWrite && OverFlow;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so write data, counter and flags all update from the same snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the array is cleared explicitly because reads after reset must be 0;
      // this forces flops rather than a RAM macro, which is acceptable at 32 entries.
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_flag_zero   <= 1'b0;
      r_flag_ovf    <= 1'b0;
      r_write_count <= '0;
    end else begin
      if (w_commit) begin
        r_regs[WriteReg] <= WriteData;
        r_write_count    <= r_write_count + 16'd1;
      end
      if (FlagWrite) begin
        r_flag_zero <= Zero0;
      end
      // Set has priority over clear so a same-cycle overflow is never lost.
      if (w_ovf_set) begin
        r_flag_ovf <= 1'b1;
      end else if (ClearOvf) begin
        r_flag_ovf <= 1'b0;
      end
    end
  end

  // r0 is forced to zero at the read mux, independent of array contents.
  assign ReadData1  = (ReadReg1 == 5'd0) ? 32'd0 : r_regs[ReadReg1];
  assign ReadData2  = (ReadReg2 == 5'd0) ? 32'd0 : r_regs[ReadReg2];
  assign FlagZero   = r_flag_zero;
  assign FlagOvf    = r_flag_ovf;
  assign WriteCount = r_write_count;

endmodule

// File: tb/tb_register_file32.sv
// Self-checking bench for register_file32: directed scenarios plus random
// traffic compared against an array-based reference model.
module tb_register_file32;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        FlagWrite;
  logic        Zero0;
  logic        OverFlow;
  logic        ClearOvf;
  logic        FlagZero;
  logic        FlagOvf;
  logic [15:0] WriteCount;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  int unsigned m_count;
  logic        m_fz;
  logic        m_fo;

  register_file32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .FlagWrite (FlagWrite),
    .Zero0     (Zero0),
    .OverFlow  (OverFlow),
    .ClearOvf  (ClearOvf),
    .FlagZero  (FlagZero),
    .FlagOvf   (FlagOvf),
    .WriteCount(WriteCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs present now, then cross one rising edge.
  task automatic tick();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count = 0;
      m_fz    = 1'b0;
      m_fo    = 1'b0;
    end else begin
      if (RegWrite && WriteReg != 5'd0) begin
        m_regs[WriteReg] = WriteData;
        m_count = (m_count + 1) % 65536;
      end
      if (FlagWrite) m_fz = Zero0;
      if (FlagWrite && OverFlow) m_fo = 1'b1;
      else if (ClearOvf)         m_fo = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    #1;
    check({tag, ".rd1"},   ReadData1, (ReadReg1 == 5'd0) ? 32'd0 : m_regs[ReadReg1]);
    check({tag, ".rd2"},   ReadData2, (ReadReg2 == 5'd0) ? 32'd0 : m_regs[ReadReg2]);
    check({tag, ".count"}, {16'd0, WriteCount}, m_count);
    check({tag, ".fz"},    {31'd0, FlagZero}, {31'd0, m_fz});
    check({tag, ".fo"},    {31'd0, FlagOvf},  {31'd0, m_fo});
  endtask

  task automatic idle();
    RegWrite = 1'b0; FlagWrite = 1'b0; ClearOvf = 1'b0;
    OverFlow = 1'b0; Zero0 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; idle();
    WriteReg = '0; WriteData = '0; ReadReg1 = '0; ReadReg2 = '0;
    tick(); tick();
    rst_n = 1'b1;

    // Post-reset: every index reads zero, counter and flags cleared
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i); #1;
      check("reset.rd1", ReadData1, 32'd0);
      check("reset.rd2", ReadData2, 32'd0);
    end
    check("reset.count", {16'd0, WriteCount}, 32'd0);
    check("reset.flags", {30'd0, FlagZero, FlagOvf}, 32'd0);

    // Write-then-read
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
    tick();
    RegWrite = 1'b0; ReadReg1 = 5'd5; #1;
    check("wr5.rd1", ReadData1, 32'hDEADBEEF);
    check("wr5.count", {16'd0, WriteCount}, 32'd1);

    // Register zero discards writes
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678;
    tick();
    RegWrite = 1'b0; ReadReg2 = 5'd0; #1;
    check("r0.rd2", ReadData2, 32'd0);
    check("r0.count", {16'd0, WriteCount}, 32'd1);

    // No same-cycle bypass
    ReadReg1 = 5'd7; RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'hA5A5A5A5; #1;
    check("nobypass.before", ReadData1, 32'd0);
    tick();
    RegWrite = 1'b0; #1;
    check("nobypass.after", ReadData1, 32'hA5A5A5A5);

    // Both ports on the same register
    ReadReg1 = 5'd5; ReadReg2 = 5'd5; #1;
    check("sameaddr", ReadData2, ReadData1 & 32'hFFFFFFFF);
    check("sameaddr.val", ReadData2, 32'hDEADBEEF);

    // Sticky overflow and zero flag
    FlagWrite = 1'b1; OverFlow = 1'b1; Zero0 = 1'b1; tick();
    check("ovf.set", {31'd0, FlagOvf}, 32'd1);
    check("fz.load1", {31'd0, FlagZero}, 32'd1);
    OverFlow = 1'b0; Zero0 = 1'b0; tick();
    check("ovf.sticky", {31'd0, FlagOvf}, 32'd1);
    check("fz.load0", {31'd0, FlagZero}, 32'd0);
    FlagWrite = 1'b0; Zero0 = 1'b1; ClearOvf = 1'b1; tick();
    check("ovf.clear", {31'd0, FlagOvf}, 32'd0);
    check("fz.hold", {31'd0, FlagZero}, 32'd0);
    FlagWrite = 1'b1; OverFlow = 1'b1; ClearOvf = 1'b1; tick();
    check("ovf.setwins", {31'd0, FlagOvf}, 32'd1);
    idle();

    // Glitch between edges must not change state
    ReadReg1 = 5'd9;
    #1 RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'hFFFF0000;
    #1 RegWrite = 1'b0;
    tick();
    check("glitch.r9", ReadData1, 32'd0);
    check("glitch.count", {16'd0, WriteCount}, 32'd2);

    // Random traffic against the model, with occasional mid-stream resets
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      RegWrite  = 1'($urandom);
      WriteReg  = 5'($urandom);
      WriteData = $urandom;
      ReadReg1  = 5'($urandom);
      ReadReg2  = ($urandom_range(0, 3) == 0) ? ReadReg1 : 5'($urandom);
      FlagWrite = 1'($urandom);
      Zero0     = 1'($urandom);
      OverFlow  = 1'($urandom);
      ClearOvf  = 1'($urandom);
      check_model("rand");
      tick();
    end
    rst_n = 1'b1; idle();
    check_model("rand.end");

    // Reset mid-operation with a concurrent write and flag set
    for (int i = 1; i < 32; i++) begin
      RegWrite = 1'b1; WriteReg = 5'(i); WriteData = 32'(i);
      tick();
    end
    RegWrite = 1'b0; ReadReg1 = 5'd17; ReadReg2 = 5'd31; #1;
    check("fill.r17", ReadData1, 32'd17);
    check("fill.r31", ReadData2, 32'd31);
    rst_n = 1'b0; RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'hFFFFFFFF;
    FlagWrite = 1'b1; OverFlow = 1'b1; Zero0 = 1'b1;
    tick();
    rst_n = 1'b1; idle();
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(i); #1;
      check("midrst.rd1", ReadData1, 32'd0);
      check("midrst.rd2", ReadData2, 32'd0);
    end
    check("midrst.count", {16'd0, WriteCount}, 32'd0);
    check("midrst.fz", {31'd0, FlagZero}, 32'd0);
    check("midrst.fo", {31'd0, FlagOvf}, 32'd0);

    // Counter wrap: 65537 committed writes
    RegWrite = 1'b1;
    for (int n = 0; n < 65537; n++) begin
      WriteReg  = 5'($urandom_range(1, 31));
      WriteData = $urandom;
      tick();
      if (n == 65534) check("wrap.ffff", {16'd0, WriteCount}, 32'h0000FFFF);
      if (n == 65535) check("wrap.0000", {16'd0, WriteCount}, 32'h00000000);
    end
    RegWrite = 1'b0;
    check("wrap.0001", {16'd0, WriteCount}, 32'h00000001);
    ReadReg1 = WriteReg; ReadReg2 = 5'd0;
    check_model("wrap.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file32.md
REGISTER_FILE32 -- requirements
Module: register_file32

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits, depth at 32 registers, and address width at 5 bits.
REQ-002 The block SHALL use one clock and one reset; reset is synchronous and active-low.
REQ-003 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  Synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 RegWrite  input  1  Write enable for the register array.
REQ-006 WriteReg  input  5  Destination register index.
REQ-007 WriteData  input  32  Data to write.
REQ-008 ReadReg1  input  5  Source index, port 1, which drives ALU operand a.
REQ-009 ReadReg2  input  5  Source index, port 2, which drives ALU operand b.
REQ-010 ReadData1  output  32  Contents of ReadReg1.
REQ-011 ReadData2  output  32  Contents of ReadReg2.
REQ-012 FlagWrite  input  1  Enable to capture the ALU status into the flag register.
REQ-013 Zero0  input  1  ALU zero indication.
REQ-014 OverFlow  input  1  ALU overflow indication.
REQ-015 ClearOvf  input  1  Clears the sticky overflow flag.
REQ-016 FlagZero  output  1  Registered zero flag.
REQ-017 FlagOvf  output  1  Sticky overflow flag.
REQ-018 WriteCount  output  16  Count of committed register writes.

Function
REQ-019 Reads SHALL be combinational (zero-cycle latency) from the current array contents.
REQ-020 A write in cycle N SHALL be visible on the read ports only after the rising edge ending cycle N; there is no same-cycle write-to-read bypass.
REQ-021 When RegWrite=1 and WriteReg!=0, WriteData SHALL be stored in register WriteReg at the rising edge.
REQ-022 Register 0 SHALL always read 0x00000000; writes to it are discarded and do not increment WriteCount.
REQ-023 WriteCount SHALL increment by 1 on each committed write, i.e. RegWrite=1 and WriteReg!=0.
REQ-024 WriteCount SHALL wrap from 0xFFFF to 0x0000 without saturating.
REQ-025 When FlagWrite=1, FlagZero SHALL load Zero0 at the edge; otherwise FlagZero holds.
REQ-026 When FlagWrite=1 and OverFlow=1, FlagOvf SHALL set to 1; it holds until cleared.
REQ-027 When ClearOvf=1 and no set occurs in the same cycle, FlagOvf SHALL clear to 0.
REQ-028 When ClearOvf=1 and a set occurs in the same cycle (FlagWrite=1, OverFlow=1), set SHALL win and FlagOvf=1.
REQ-029 When both ports address the same register, both SHALL return identical data.
REQ-030 All inputs SHALL be sampled only at the rising edge; input glitches between edges SHALL NOT affect state.

Reset
REQ-031 When rst_n=0 at a rising edge, all 32 registers, FlagZero, FlagOvf and WriteCount SHALL become 0.
REQ-032 During that reset edge, any concurrent write or flag update SHALL be ignored.
REQ-033 Reset SHALL take effect even mid-operation, with no partial writes.
REQ-034 Before the first reset edge, outputs SHALL be undefined; the bench SHALL apply reset for at least 1 cycle first.
REQ-035 After release (rst_n=1), ReadData1 and ReadData2 SHALL read 0 for every index until that register is written.

Verification
REQ-036 Write-then-read: write 0xDEADBEEF to r5, then set ReadReg1=5 -> ReadData1=0xDEADBEEF on the next cycle, and WriteCount=1.
REQ-037 Register zero: write 0x12345678 to r0, set ReadReg2=0 -> ReadData2=0x00000000 and WriteCount unchanged.
REQ-038 No bypass: in the same cycle write 0xA5A5A5A5 to r7 with ReadReg1=7 (r7 previously 0) -> ReadData1=0 in that cycle and 0xA5A5A5A5 after the edge.
REQ-039 Sticky overflow: FlagWrite=1 with OverFlow=1, then FlagWrite=1 with OverFlow=0 -> FlagOvf stays 1; ClearOvf=1 alone -> FlagOvf=0; ClearOvf=1 together with a set -> FlagOvf=1.
REQ-040 Reset mid-operation: fill r1..r31 with their index values, assert rst_n=0 for 1 cycle while RegWrite=1 -> all reads return 0, WriteCount=0, FlagZero=0, FlagOvf=0.
REQ-041 Counter wrap: perform 65537 committed writes -> WriteCount=0x0001.
